// File: rtl/fir_coef_streamer_if.sv
// Coefficient bus between the streamer (master) and the FIR datapath receiver (slave).
// One coefficient per out_ing_valid pulse; out_valid frames the whole burst.
interface fir_coef_streamer_if #(
    parameter int CNT_W  = 6,
    parameter int COEF_W = 16
);
    logic                     out_valid;
    logic                     out_ing_valid;
    logic [CNT_W-1:0]         out_cnt;
    logic signed [COEF_W-1:0] fir_value;

    modport master (output out_valid, out_ing_valid, out_cnt, fir_value);
    modport slave  (input  out_valid, out_ing_valid, out_cnt, fir_value);
endinterface

// File: rtl/fir_coef_streamer.sv
// Streams a host-loaded bank of TAPS_HALF signed coefficients onto the FIR coefficient bus.
// First pulse 2 cycles after start, then one every GAP+1 cycles; no backpressure, abort stops the burst.
module fir_coef_streamer #(
    parameter int TAPS_HALF = 32,
    parameter int CNT_W     = 6,
    parameter int COEF_W    = 16,
    parameter int GAP       = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [CNT_W-1:0]         wr_addr,
    input  logic signed [COEF_W-1:0] wr_data,
    input  logic                     start,
    input  logic                     abort,
    fir_coef_streamer_if.master      coef,
    output logic                     busy,
    output logic                     done,
    output logic                     wr_err
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND, S_GAP, S_DONE} state_t;

    localparam int                IDX_W    = (TAPS_HALF > 1) ? $clog2(TAPS_HALF) : 1;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(TAPS_HALF - 1);
    localparam logic [CNT_W:0]    TAPS_LIM = (CNT_W + 1)'(TAPS_HALF);
    localparam int                GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         idx, idx_nxt;
    logic [GAP_W-1:0]         gap_cnt, gap_cnt_nxt;
    logic                     load;
    logic                     wr_ok;
    logic signed [COEF_W-1:0] fir_q;
    logic signed [COEF_W-1:0] bank [TAPS_HALF];

    assign wr_ok = wr_en && (state == S_IDLE) && ({1'b0, wr_addr} < TAPS_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS_HALF; i++) begin
                bank[i] <= '0;
            end
        end else if (wr_ok) begin
            bank[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    // The next coefficient is fetched in the cycle before its pulse, so the
    // fetch overlaps SEND (GAP=0) or the last GAP cycle instead of adding one.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        gap_cnt_nxt = gap_cnt;
        load        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_nxt = S_FETCH;
                    idx_nxt   = '0;
                end
            end
            S_FETCH: begin
                load      = 1'b1;
                state_nxt = S_SEND;
            end
            S_SEND: begin
                if (idx == LAST_IDX) begin
                    state_nxt = S_DONE;
                    idx_nxt   = '0;
                end else if (GAP == 0) begin
                    idx_nxt = idx + 1'b1;
                    load    = 1'b1;
                end else begin
                    state_nxt   = S_GAP;
                    gap_cnt_nxt = '0;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = S_SEND;
                    idx_nxt   = idx + 1'b1;
                    load      = 1'b1;
                end else begin
                    gap_cnt_nxt = gap_cnt + 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
            idx_nxt   = '0;
            load      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            idx     <= '0;
            gap_cnt <= '0;
            fir_q   <= '0;
            wr_err  <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            gap_cnt <= gap_cnt_nxt;
            wr_err  <= wr_en && !wr_ok;
            if (load) begin
                fir_q <= bank[idx_nxt[IDX_W-1:0]];
            end
        end
    end

    assign coef.out_valid     = (state == S_SEND) || (state == S_GAP);
    assign coef.out_ing_valid = (state == S_SEND);
    assign coef.out_cnt       = coef.out_valid ? idx : '0;
    assign coef.fir_value     = fir_q;
    assign busy               = (state != S_IDLE);
    assign done               = (state == S_DONE);
endmodule

// File: tb/tb_fir_coef_streamer.sv
// Drives a GAP=3 and a GAP=0 streamer with identical stimulus and checks both against a pulse-schedule model.
module tb_fir_coef_streamer;
    logic clk = 1'b0;
    logic rst_n;
    logic wr_en;
    logic [5:0] wr_addr;
    logic signed [15:0] wr_data;
    logic start;
    logic abort;
    logic [1:0] o_busy, o_done, o_werr, o_ov, o_ing;
    logic [5:0] o_cnt [2];
    logic signed [15:0] o_fir [2];

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    fir_coef_streamer_if #(.CNT_W(6), .COEF_W(16)) cb0 ();
    fir_coef_streamer_if #(.CNT_W(6), .COEF_W(16)) cb1 ();

    fir_coef_streamer #(.TAPS_HALF(32), .CNT_W(6), .COEF_W(16), .GAP(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .abort(abort), .coef(cb0),
        .busy(o_busy[0]), .done(o_done[0]), .wr_err(o_werr[0]));

    fir_coef_streamer #(.TAPS_HALF(32), .CNT_W(6), .COEF_W(16), .GAP(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .abort(abort), .coef(cb1),
        .busy(o_busy[1]), .done(o_done[1]), .wr_err(o_werr[1]));

    assign o_ov     = {cb1.out_valid, cb0.out_valid};
    assign o_ing    = {cb1.out_ing_valid, cb0.out_ing_valid};
    assign o_cnt[0] = cb0.out_cnt;
    assign o_cnt[1] = cb1.out_cnt;
    assign o_fir[0] = cb0.fir_value;
    assign o_fir[1] = cb1.fir_value;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: a stream accepted in cycle t0 puts pulse k at t0+2+k*period, done one cycle after the last.
    int m_bank [2][32];
    bit m_act [2];
    int m_t0 [2];
    int m_last_fir [2];
    bit m_err_pend [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int p, lastr, rel, k, e_cnt, e_fir;
            bit e_ov, e_ing, e_busy, e_done, e_err, wr_ok;
            p     = (d == 0) ? 4 : 1;
            lastr = 2 + 31 * p;
            rel   = cyc - m_t0[d];
            e_ov = 0; e_ing = 0; e_busy = 0; e_done = 0; e_cnt = 0;
            if (!rst_n) begin
                m_act[d] = 0;
                m_last_fir[d] = 0;
                m_err_pend[d] = 0;
                for (int i = 0; i < 32; i++) m_bank[d][i] = 0;
            end
            e_fir = m_last_fir[d];
            e_err = m_err_pend[d];
            if (m_act[d]) begin
                e_busy = 1;
                if (rel >= 2 && rel <= lastr) begin
                    e_ov  = 1;
                    k     = (rel - 2) / p;
                    e_ing = ((rel - 2) % p) == 0;
                    e_cnt = k;
                    e_fir = m_bank[d][k];
                end
                e_done = (rel == lastr + 1);
            end
            chk($sformatf("dut%0d out_valid @%0d", d, cyc), int'(o_ov[d]), int'(e_ov));
            chk($sformatf("dut%0d out_ing_valid @%0d", d, cyc), int'(o_ing[d]), int'(e_ing));
            chk($sformatf("dut%0d out_cnt @%0d", d, cyc), int'(o_cnt[d]), e_cnt);
            chk($sformatf("dut%0d fir_value @%0d", d, cyc), int'(o_fir[d]), e_fir);
            chk($sformatf("dut%0d busy @%0d", d, cyc), int'(o_busy[d]), int'(e_busy));
            chk($sformatf("dut%0d done @%0d", d, cyc), int'(o_done[d]), int'(e_done));
            chk($sformatf("dut%0d wr_err @%0d", d, cyc), int'(o_werr[d]), int'(e_err));
            if (rst_n) begin
                m_last_fir[d] = e_fir;
                wr_ok = wr_en && !m_act[d] && (int'(wr_addr) < 32);
                m_err_pend[d] = wr_en && !wr_ok;
                if (wr_ok) m_bank[d][wr_addr] = int'(wr_data);
                if (m_act[d]) begin
                    if (abort || rel == lastr + 1) m_act[d] = 0;
                end else if (start && !abort) begin
                    m_act[d] = 1;
                    m_t0[d]  = cyc;
                end
            end
        end
    end

    int pulses0, pulses1, dones0;

    task automatic step();
        @(posedge clk);
        #1;
        if (o_ing[0]) pulses0++;
        if (o_ing[1]) pulses1++;
        if (o_done[0]) dones0++;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n = 0; wr_en = 0; wr_addr = 0; wr_data = 0; start = 0; abort = 0;
        repeat (3) step();
        chk("reset busy", int'(o_busy[0]), 0);
        chk("reset fir_value", int'(o_fir[0]), 0);
        rst_n = 1;
        step();
        for (int k = 0; k < 32; k++) begin
            wr_en = 1; wr_addr = 6'(k); wr_data = 16'(k * 100 - 1600);
            step();
        end
        wr_en = 0;
        step();

        // Full stream; busy-time write and a stray start are both rejected.
        t = cyc; pulses0 = 0; pulses1 = 0;
        start = 1; step(); start = 0;
        wait_until(t + 2);
        chk("s1 first fir dut0", int'(o_fir[0]), -1600);
        chk("s1 first pulse dut1", int'(o_ing[1]), 1);
        wait_until(t + 10);
        wr_en = 1; wr_addr = 6'd5; wr_data = 16'sd7;
        step(); wr_en = 0;
        chk("busy write wr_err", int'(o_werr[0]), 1);
        wait_until(t + 20);
        start = 1; step(); start = 0;
        wait_until(t + 33);
        chk("gap0 last cnt", int'(o_cnt[1]), 31);
        chk("gap0 last fir", int'(o_fir[1]), 1500);
        wait_until(t + 34);
        chk("gap0 done", int'(o_done[1]), 1);
        wait_until(t + 126);
        chk("gap3 last cnt", int'(o_cnt[0]), 31);
        chk("gap3 last fir", int'(o_fir[0]), 1500);
        wait_until(t + 127);
        chk("gap3 done", int'(o_done[0]), 1);
        chk("gap3 out_valid fell", int'(o_ov[0]), 0);
        chk("s1 pulses dut0", pulses0, 32);
        chk("s1 pulses dut1", pulses1, 32);
        step();

        wr_en = 1; wr_addr = 6'd40; wr_data = 16'sd123;
        step(); wr_en = 0;
        chk("bad addr wr_err", int'(o_werr[1]), 1);
        step();

        // Write and start in the same cycle, with a stray start mid-stream.
        t = cyc; pulses0 = 0; pulses1 = 0;
        start = 1; wr_en = 1; wr_addr = 6'd0; wr_data = 16'sh7FFF;
        step(); start = 0; wr_en = 0;
        wait_until(t + 2);
        chk("s2 first fir", int'(o_fir[0]), 32767);
        wait_until(t + 10);
        start = 1; step(); start = 0;
        wait_until(t + 22);
        chk("s2 pulse5 cnt", int'(o_cnt[0]), 5);
        chk("s2 pulse5 fir", int'(o_fir[0]), -1100);
        wait_until(t + 140);
        chk("s2 pulses dut0", pulses0, 32);
        chk("s2 pulses dut1", pulses1, 32);

        // Abort during pulse 10 of the GAP=3 stream.
        t = cyc; pulses0 = 0; dones0 = 0;
        start = 1; step(); start = 0;
        wait_until(t + 42);
        chk("s3 pulse10 cnt", int'(o_cnt[0]), 10);
        abort = 1; step(); abort = 0;
        chk("abort out_valid", int'(o_ov[0]), 0);
        chk("abort busy", int'(o_busy[0]), 0);
        chk("abort fir held", int'(o_fir[0]), -600);
        wait_until(t + 50);
        chk("abort no done", dones0, 0);
        chk("abort pulses", pulses0, 11);

        // Restart, then reset at pulse 20.
        t = cyc;
        start = 1; step(); start = 0;
        wait_until(t + 2);
        chk("s4 restart cnt", int'(o_cnt[0]), 0);
        chk("s4 restart fir", int'(o_fir[0]), 32767);
        wait_until(t + 82);
        chk("s4 pulse20 fir", int'(o_fir[0]), 400);
        rst_n = 0;
        #1;
        chk("mid reset out_valid", int'(o_ov[0]), 0);
        chk("mid reset fir", int'(o_fir[0]), 0);
        step();
        rst_n = 1;
        step();

        // Stream without reload sends the cleared bank.
        t = cyc; pulses0 = 0; pulses1 = 0;
        start = 1; step(); start = 0;
        wait_until(t + 2);
        chk("s5 first pulse", int'(o_ing[0]), 1);
        chk("s5 first fir", int'(o_fir[0]), 0);
        wait_until(t + 140);
        chk("s5 pulses dut0", pulses0, 32);
        chk("s5 pulses dut1", pulses1, 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
